// File: rtl/dptw_sv32.sv
// Sv32 data-side page-table walker: two-level walk on DTLB miss, leaf PTE
// written to the DTLB or page fault reported; flush aborts safely.
// Ports: clk/rst_n; walk_req_i/walk_vpn_i/satp_ppn_i/flush_i start or abort
// a walk; walk_busy_o; mem_req_o/mem_addr_o/mem_ack_i/mem_rdata_i PTE reads;
// tlb_update_o/tlb_vpn_o/tlb_pte_o/tlb_page_4M_o DTLB write; walk_fault_o.
module dptw_sv32 #(
   parameter int PA_WIDTH  = 34,
   parameter int PPN_WIDTH = 22
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 walk_req_i,
   input  logic [19:0]          walk_vpn_i,
   input  logic [PPN_WIDTH-1:0] satp_ppn_i,
   input  logic                 flush_i,
   output logic                 walk_busy_o,
   output logic                 mem_req_o,
   output logic [PA_WIDTH-1:0]  mem_addr_o,
   input  logic                 mem_ack_i,
   input  logic [31:0]          mem_rdata_i,
   output logic                 tlb_update_o,
   output logic [19:0]          tlb_vpn_o,
   output logic [31:0]          tlb_pte_o,
   output logic                 tlb_page_4M_o,
   output logic                 walk_fault_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_L1, S_L0, S_DONE, S_FAULT, S_ABORT
   } state_t;

   state_t state_q, state_d;

   logic [19:0]         vpn_q;
   logic [PA_WIDTH-1:0] addr_q;
   logic [31:0]         pte_q;
   logic                page_4m_q;

   logic start;
   logic go_l0;
   logic leaf_hit;
   logic pte_ok;
   logic pte_leaf;

   // V set and not the reserved W-without-R encoding
   assign pte_ok   = mem_rdata_i[0] & ~(~mem_rdata_i[1] & mem_rdata_i[2]);
   assign pte_leaf = mem_rdata_i[1] | mem_rdata_i[3];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      mem_req_o    = 1'b0;
      tlb_update_o = 1'b0;
      walk_fault_o = 1'b0;
      start        = 1'b0;
      go_l0        = 1'b0;
      leaf_hit     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (walk_req_i && !flush_i) begin
               start   = 1'b1;
               state_d = S_L1;
            end
         end
         S_L1: begin
            mem_req_o = 1'b1;
            if (flush_i) begin
               state_d = mem_ack_i ? S_IDLE : S_ABORT;
            end else if (mem_ack_i) begin
               if (!pte_ok) begin
                  state_d = S_FAULT;
               end else if (pte_leaf) begin
                  // superpage leaf must have PPN[0] clear
                  if (mem_rdata_i[19:10] != 10'd0) begin
                     state_d = S_FAULT;
                  end else begin
                     leaf_hit = 1'b1;
                     state_d  = S_DONE;
                  end
               end else begin
                  go_l0   = 1'b1;
                  state_d = S_L0;
               end
            end
         end
         S_L0: begin
            mem_req_o = 1'b1;
            if (flush_i) begin
               state_d = mem_ack_i ? S_IDLE : S_ABORT;
            end else if (mem_ack_i) begin
               if (pte_ok && pte_leaf) begin
                  leaf_hit = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  state_d = S_FAULT;
               end
            end
         end
         S_DONE: begin
            tlb_update_o = !flush_i;
            state_d      = S_IDLE;
         end
         S_FAULT: begin
            walk_fault_o = !flush_i;
            state_d      = S_IDLE;
         end
         S_ABORT: begin
            // outstanding read cannot be retracted; drain it
            mem_req_o = 1'b1;
            if (mem_ack_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign walk_busy_o = (state_q != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vpn_q     <= '0;
         addr_q    <= '0;
         pte_q     <= '0;
         page_4m_q <= 1'b0;
      end else begin
         if (start) begin
            vpn_q  <= walk_vpn_i;
            addr_q <= {satp_ppn_i, walk_vpn_i[19:10], 2'b00};
         end
         if (go_l0) begin
            addr_q <= {mem_rdata_i[31:10], vpn_q[9:0], 2'b00};
         end
         if (leaf_hit) begin
            pte_q     <= mem_rdata_i;
            page_4m_q <= (state_q == S_L1);
         end
      end
   end

   assign mem_addr_o    = addr_q;
   assign tlb_vpn_o     = vpn_q;
   assign tlb_pte_o     = pte_q;
   assign tlb_page_4M_o = page_4m_q;

endmodule

// File: tb/tb_dptw_sv32.sv
// Self-checking bench for dptw_sv32: vector table with a scoreboard of
// expected DTLB updates/faults, plus flush, busy-request and reset sequences.
module tb_dptw_sv32;

   logic        clk;
   logic        rst_n;
   logic        walk_req_i;
   logic [19:0] walk_vpn_i;
   logic [21:0] satp_ppn_i;
   logic        flush_i;
   logic        walk_busy_o;
   logic        mem_req_o;
   logic [33:0] mem_addr_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        tlb_update_o;
   logic [19:0] tlb_vpn_o;
   logic [31:0] tlb_pte_o;
   logic        tlb_page_4M_o;
   logic        walk_fault_o;

   dptw_sv32 dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .walk_req_i    (walk_req_i),
      .walk_vpn_i    (walk_vpn_i),
      .satp_ppn_i    (satp_ppn_i),
      .flush_i       (flush_i),
      .walk_busy_o   (walk_busy_o),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_ack_i     (mem_ack_i),
      .mem_rdata_i   (mem_rdata_i),
      .tlb_update_o  (tlb_update_o),
      .tlb_vpn_o     (tlb_vpn_o),
      .tlb_pte_o     (tlb_pte_o),
      .tlb_page_4M_o (tlb_page_4M_o),
      .walk_fault_o  (walk_fault_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // memory responder: per-access latency and data, logs addresses
   logic [31:0] rd [4];
   int          lat[4];
   int          gen = 0;
   int          gen_seen = 0;
   int          acc_idx = 0;
   int          wcnt = 0;
   logic [33:0] addr_seen[$];

   initial begin
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
   end

   always @(negedge clk) begin
      if (gen != gen_seen) begin
         gen_seen = gen;
         acc_idx  = 0;
         wcnt     = 0;
         addr_seen.delete();
      end
      mem_ack_i = 1'b0;
      if (mem_req_o) begin
         if (wcnt >= lat[acc_idx]) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = rd[acc_idx];
            addr_seen.push_back(mem_addr_o);
            if (acc_idx < 3) acc_idx++;
            wcnt = 0;
         end else begin
            wcnt++;
         end
      end
   end

   task automatic setup(input logic [31:0] r0, input logic [31:0] r1,
                        input int l0, input int l1);
      rd[0]  = r0;
      rd[1]  = r1;
      rd[2]  = '0;
      rd[3]  = '0;
      lat[0] = l0;
      lat[1] = l1;
      lat[2] = 0;
      lat[3] = 0;
      gen++;
   endtask

   // scoreboard of expected walk outcomes
   typedef struct {
      logic        upd;
      logic [19:0] vpn;
      logic [31:0] pte;
      logic        m4;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   req_cyc = 0;
   int   ev_cnt  = 0;
   int   ev_cyc  = 0;

   always @(negedge clk) begin
      if (rst_n && (tlb_update_o || walk_fault_o)) begin
         ev_cnt++;
         ev_cyc = cyc;
         if (exp_q.size() == 0) begin
            chk("unexpected_event", {tlb_update_o, walk_fault_o}, 2'b00);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("event_kind", {tlb_update_o, walk_fault_o},
                e.upd ? 2'b10 : 2'b01);
            chk("latency", cyc - req_cyc, e.lat);
            if (e.upd) begin
               chk("tlb_vpn", tlb_vpn_o, e.vpn);
               chk("tlb_pte", tlb_pte_o, e.pte);
               chk("tlb_4M", tlb_page_4M_o, e.m4);
            end
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (walk_busy_o && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("idle_timeout", walk_busy_o, 1'b0);
   endtask

   typedef struct {
      logic [19:0] vpn;
      logic [21:0] satp;
      logic [31:0] d0;
      logic [31:0] d1;
      int          nacc;
      logic [33:0] a0;
      logic [33:0] a1;
      logic        upd;
      logic        m4;
      logic [31:0] pte;
      int          lat;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int e0;
      tbl[0] = '{20'h00401, 22'h00010, 32'h0000_00CF, 32'h0, 1,
                 34'h0_0001_0004, 34'h0, 1'b1, 1'b1, 32'h0000_00CF, 2};
      tbl[1] = '{20'h00401, 22'h00010, 32'h0000_8001, 32'h0012_34C7, 2,
                 34'h0_0001_0004, 34'h0_0002_0004, 1'b1, 1'b0,
                 32'h0012_34C7, 3};
      tbl[2] = '{20'h00401, 22'h00010, 32'h0000_0000, 32'h0, 1,
                 34'h0_0001_0004, 34'h0, 1'b0, 1'b0, 32'h0, 2};
      tbl[3] = '{20'h00401, 22'h00010, 32'h0000_04CF, 32'h0, 1,
                 34'h0_0001_0004, 34'h0, 1'b0, 1'b0, 32'h0, 2};
      tbl[4] = '{20'h00401, 22'h00010, 32'h0000_8001, 32'h0000_0401, 2,
                 34'h0_0001_0004, 34'h0_0002_0004, 1'b0, 1'b0, 32'h0, 3};
      tbl[5] = '{20'h00401, 22'h00010, 32'h0000_8001, 32'h0000_0005, 2,
                 34'h0_0001_0004, 34'h0_0002_0004, 1'b0, 1'b0, 32'h0, 3};
      tbl[6] = '{20'hFFFFF, 22'h3FFFFF, 32'h1234_5401, 32'hABCD_E00B, 2,
                 34'h3_FFFF_FFFC, 34'h0_48D1_5FFC, 1'b1, 1'b0,
                 32'hABCD_E00B, 3};
      tbl[7] = '{20'h12345, 22'h00ABC, 32'h00C0_0009, 32'h0, 1,
                 34'h0_00AB_C120, 34'h0, 1'b1, 1'b1, 32'h00C0_0009, 2};

      rst_n      = 1'b0;
      walk_req_i = 1'b0;
      walk_vpn_i = '0;
      satp_ppn_i = '0;
      flush_i    = 1'b0;
      setup(32'h0, 32'h0, 0, 0);
      #22;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_ctrl", {walk_busy_o, mem_req_o, tlb_update_o,
                       walk_fault_o, tlb_page_4M_o}, 5'd0);
      chk("rst_addr", mem_addr_o, 34'h0);
      chk("rst_vpn", tlb_vpn_o, 20'h0);
      chk("rst_pte", tlb_pte_o, 32'h0);

      for (int i = 0; i < 8; i++) begin
         setup(tbl[i].d0, tbl[i].d1, 0, 0);
         exp_q.push_back('{tbl[i].upd, tbl[i].vpn, tbl[i].pte,
                           tbl[i].m4, tbl[i].lat});
         @(posedge clk);
         #1;
         walk_req_i = 1'b1;
         walk_vpn_i = tbl[i].vpn;
         satp_ppn_i = tbl[i].satp;
         req_cyc    = cyc;
         @(posedge clk);
         #1;
         walk_req_i = 1'b0;
         wait_idle();
         chk("idle_next_cycle", cyc - ev_cyc, 1);
         chk("sb_drained", exp_q.size(), 0);
         chk("n_access", addr_seen.size(), tbl[i].nacc);
         if (addr_seen.size() > 0) chk("addr_l1", addr_seen[0], tbl[i].a0);
         if (tbl[i].nacc > 1 && addr_seen.size() > 1)
            chk("addr_l0", addr_seen[1], tbl[i].a1);
      end

      // flush in L0, ack arrives later: request held until drained
      setup(32'h0000_8001, 32'h0012_34C7, 0, 3);
      e0 = ev_cnt;
      @(posedge clk); #1;
      walk_req_i = 1'b1;
      walk_vpn_i = 20'h00401;
      satp_ppn_i = 22'h00010;
      @(posedge clk); #1;
      walk_req_i = 1'b0;
      @(posedge clk); #1;
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      chk("abort_req", mem_req_o, 1'b1);
      begin
         int n;
         n = 0;
         do begin
            @(negedge clk); #1;
            chk("abort_hold", mem_req_o, 1'b1);
            chk("abort_addr", mem_addr_o, 34'h0_0002_0004);
            n++;
         end while (!mem_ack_i && n < 10);
      end
      chk("abort_ack", mem_ack_i, 1'b1);
      @(posedge clk); #1;
      chk("abort_idle", {walk_busy_o, mem_req_o}, 2'b00);
      @(posedge clk); #1;
      chk("abort_no_event", ev_cnt - e0, 0);

      // flush in the same cycle as the L1 ack
      setup(32'h0000_00CF, 32'h0, 0, 0);
      e0 = ev_cnt;
      @(posedge clk); #1;
      walk_req_i = 1'b1;
      @(posedge clk); #1;
      walk_req_i = 1'b0;
      flush_i    = 1'b1;
      @(negedge clk); #1;
      chk("flush_ack_seen", mem_ack_i, 1'b1);
      @(posedge clk); #1;
      flush_i = 1'b0;
      chk("flush_ack_idle", {walk_busy_o, mem_req_o}, 2'b00);
      @(posedge clk); #1;
      chk("flush_ack_no_event", ev_cnt - e0, 0);

      // flush in DONE suppresses the update
      setup(32'h0000_00CF, 32'h0, 0, 0);
      e0 = ev_cnt;
      @(posedge clk); #1;
      walk_req_i = 1'b1;
      @(posedge clk); #1;
      walk_req_i = 1'b0;
      @(posedge clk); #1;
      flush_i = 1'b1;
      @(negedge clk); #1;
      chk("done_flush_upd", {tlb_update_o, walk_fault_o}, 2'b00);
      @(posedge clk); #1;
      flush_i = 1'b0;
      chk("done_flush_idle", walk_busy_o, 1'b0);
      chk("done_flush_no_event", ev_cnt - e0, 0);

      // request with flush in IDLE is dropped
      setup(32'h0000_00CF, 32'h0, 0, 0);
      @(posedge clk); #1;
      walk_req_i = 1'b1;
      flush_i    = 1'b1;
      @(posedge clk); #1;
      walk_req_i = 1'b0;
      flush_i    = 1'b0;
      chk("flush_drop_req", {walk_busy_o, mem_req_o}, 2'b00);

      // second request while busy is ignored
      setup(32'h0000_8001, 32'h0012_34C7, 0, 0);
      exp_q.push_back('{1'b1, 20'h00401, 32'h0012_34C7, 1'b0, 3});
      @(posedge clk); #1;
      walk_req_i = 1'b1;
      walk_vpn_i = 20'h00401;
      satp_ppn_i = 22'h00010;
      req_cyc    = cyc;
      @(posedge clk); #1;
      walk_vpn_i = 20'hAAAAA;
      satp_ppn_i = 22'h00155;
      @(posedge clk); #1;
      walk_req_i = 1'b0;
      wait_idle();
      chk("busy_req_sb", exp_q.size(), 0);
      chk("busy_req_nacc", addr_seen.size(), 2);
      if (addr_seen.size() > 1) begin
         chk("busy_req_a0", addr_seen[0], 34'h0_0001_0004);
         chk("busy_req_a1", addr_seen[1], 34'h0_0002_0004);
      end

      // async reset with a read outstanding
      setup(32'h0000_00CF, 32'h0, 20, 0);
      @(posedge clk); #1;
      walk_req_i = 1'b1;
      walk_vpn_i = 20'h12345;
      satp_ppn_i = 22'h00ABC;
      @(posedge clk); #1;
      walk_req_i = 1'b0;
      @(negedge clk); #1;
      chk("pre_rst_req", mem_req_o, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_ctrl", {walk_busy_o, mem_req_o, tlb_update_o,
                        walk_fault_o, tlb_page_4M_o}, 5'd0);
      chk("arst_addr", mem_addr_o, 34'h0);
      chk("arst_vpn", tlb_vpn_o, 20'h0);
      chk("arst_pte", tlb_pte_o, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_idle", {walk_busy_o, mem_req_o}, 2'b00);

      chk("final_sb_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

endmodule
